// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit
//   Instruction fetch stage that sits directly in front of the dual-port
//   instruction/data BRAM. A free-running 4-phase one-hot strobe sequence
//   (i1re -> i2re -> dre -> gwe) drives the BRAM. Each 4-cycle group fetches
//   the pair (pc, pc+1). At the end of the group the pair is either handed to
//   decode through a single valid/ready holding register, or dropped. A pair
//   is dropped when decode is still busy or when a branch redirect is pending.
//
// Ports
//   clk, rst                  single clock, synchronous active-high reset
//   i1re, i2re, dre, gwe      one-hot phase strobes to the BRAM
//   i1addr, i2addr            registered fetch addresses (pc, pc+1)
//   i1in, i2in                BRAM read data for the two instruction ports
//   redirect_valid/_pc        one-cycle flush request and new fetch target
//   ins_ready                 decode accepts the held pair at this edge
//   ins_valid, ins0, ins1,    fetched pair presented to decode
//   ins_pc
module dual_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              i1re,
  output logic              i2re,
  output logic              dre,
  output logic              gwe,
  output logic [ADDR_W-1:0] i1addr,
  output logic [ADDR_W-1:0] i2addr,
  input  logic [15:0]       i1in,
  input  logic [15:0]       i2in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              ins_ready,
  output logic              ins_valid,
  output logic [15:0]       ins0,
  output logic [15:0]       ins1,
  output logic [ADDR_W-1:0] ins_pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

  logic              run_reg, run_next;
  logic [1:0]        phase_reg, phase_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              redirect_pend_reg, redirect_pend_next;
  logic [ADDR_W-1:0] redirect_target_reg, redirect_target_next;
  logic              ins_valid_reg, ins_valid_next;
  logic [15:0]       ins0_reg, ins0_next;
  logic [15:0]       ins1_reg, ins1_next;
  logic [ADDR_W-1:0] ins_pc_reg, ins_pc_next;
  logic [ADDR_W-1:0] i1addr_reg, i1addr_next;
  logic [ADDR_W-1:0] i2addr_reg, i2addr_next;
  logic [3:0]        strobe_vec;
  logic              group_end;

  // One-hot phase decode. Strobes are also forced low combinationally while
  // rst is high, so that a mid-group reset silences the BRAM immediately.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_strobe
      assign strobe_vec[gi] = run_reg & ~rst & (phase_reg == 2'(gi));
    end
  endgenerate

  assign i1re = strobe_vec[0];
  assign i2re = strobe_vec[1];
  assign dre  = strobe_vec[2];
  assign gwe  = strobe_vec[3];

  assign group_end = run_reg && (phase_reg == 2'd3);

  always_comb begin
    run_next             = 1'b1;
    phase_next           = run_reg ? phase_reg + 2'd1 : phase_reg;
    pc_next              = pc_reg;
    redirect_pend_next   = redirect_pend_reg;
    redirect_target_next = redirect_target_reg;
    ins_valid_next       = ins_valid_reg;
    ins0_next            = ins0_reg;
    ins1_next            = ins1_reg;
    ins_pc_next          = ins_pc_reg;
    i1addr_next          = i1addr_reg;
    i2addr_next          = i2addr_reg;

    if (group_end) begin
      if (redirect_valid || redirect_pend_reg) begin
        // A redirect outranks the capture. The fetched pair is on the wrong path.
        pc_next            = redirect_valid ? redirect_pc : redirect_target_reg;
        redirect_pend_next = 1'b0;
        ins_valid_next     = 1'b0;
      end else if (!ins_valid_reg || ins_ready) begin
        ins0_next      = i1in;
        ins1_next      = i2in;
        ins_pc_next    = pc_reg;
        ins_valid_next = 1'b1;
        pc_next        = pc_reg + PC_TWO;
      end
      // Otherwise the slot is still occupied. The pair is dropped and pc is
      // kept, so the same pair is fetched again by the next group.
      i1addr_next = pc_next;
      i2addr_next = pc_next + PC_ONE;
    end else begin
      if (redirect_valid) begin
        // Flush now and defer the pc change to the group boundary. This keeps
        // the addresses stable for the rest of the in-flight group.
        ins_valid_next       = 1'b0;
        redirect_pend_next   = 1'b1;
        redirect_target_next = redirect_pc;
      end else if (ins_valid_reg && ins_ready) begin
        ins_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_reg             <= 1'b0;
      phase_reg           <= 2'd0;
      pc_reg              <= RESET_PC;
      redirect_pend_reg   <= 1'b0;
      redirect_target_reg <= RESET_PC;
      ins_valid_reg       <= 1'b0;
      ins0_reg            <= 16'h0000;
      ins1_reg            <= 16'h0000;
      ins_pc_reg          <= RESET_PC;
      i1addr_reg          <= RESET_PC;
      i2addr_reg          <= RESET_PC + PC_ONE;
    end else begin
      run_reg             <= run_next;
      phase_reg           <= phase_next;
      pc_reg              <= pc_next;
      redirect_pend_reg   <= redirect_pend_next;
      redirect_target_reg <= redirect_target_next;
      ins_valid_reg       <= ins_valid_next;
      ins0_reg            <= ins0_next;
      ins1_reg            <= ins1_next;
      ins_pc_reg          <= ins_pc_next;
      i1addr_reg          <= i1addr_next;
      i2addr_reg          <= i2addr_next;
    end
  end

  assign i1addr    = i1addr_reg;
  assign i2addr    = i2addr_reg;
  assign ins_valid = ins_valid_reg;
  assign ins0      = ins0_reg;
  assign ins1      = ins1_reg;
  assign ins_pc    = ins_pc_reg;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Testbench for dual_fetch_unit: table-driven cycle vectors plus
// hand-written redirect, wrap-around and mid-group reset sequences.
module tb_dual_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i1re, i2re, dre, gwe;
  logic [15:0] i1addr, i2addr;
  logic [15:0] i1in = 16'h0000;
  logic [15:0] i2in = 16'h0000;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        ins_ready = 1'b0;
  logic        ins_valid;
  logic [15:0] ins0, ins1, ins_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .i1re           (i1re),
    .i2re           (i2re),
    .dre            (dre),
    .gwe            (gwe),
    .i1addr         (i1addr),
    .i2addr         (i2addr),
    .i1in           (i1in),
    .i2in           (i2in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_ready      (ins_ready),
    .ins_valid      (ins_valid),
    .ins0           (ins0),
    .ins1           (ins1),
    .ins_pc         (ins_pc)
  );

  // BRAM model: word at address a is 16'h1000 + a. Read data is registered
  // on the matching strobe.
  always @(posedge clk) begin
    if (i1re) i1in <= 16'h1000 + i1addr;
    if (i2re) i2in <= 16'h1000 + i2addr;
  end

  // Strobe encoding used in the vectors: {i1re, i2re, dre, gwe}.
  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic [3:0]  strb;
    logic        vld;
    logic        chk_ins;
    logic [15:0] i0;
    logic [15:0] i1;
    logic [15:0] ipc;
    logic [15:0] a1;
    logic [15:0] a2;
  } vec_t;

  function automatic vec_t mk(logic r, logic rv, logic [15:0] rpc, logic rdy,
                              logic [3:0] strb, logic vld, logic chk_ins,
                              logic [15:0] i0, logic [15:0] i1, logic [15:0] ipc,
                              logic [15:0] a1, logic [15:0] a2);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.strb = strb; v.vld = vld;
    v.chk_ins = chk_ins; v.i0 = i0; v.i1 = i1; v.ipc = ipc; v.a1 = a1; v.a2 = a2;
    return v;
  endfunction

  function automatic logic [3:0] ph(int p);
    logic [3:0] s;
    s = 4'b1000 >> (p % 4);
    return s;
  endfunction

  task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Apply one vector's inputs, clock once and compare 1 time unit after the edge.
  task automatic apply(vec_t v, string tag);
    rst            = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    ins_ready      = v.rdy;
    @(posedge clk);
    #1;
    $display("%s: strb=%b vld=%b ins0=%h ins1=%h ins_pc=%h i1addr=%h i2addr=%h",
             tag, {i1re, i2re, dre, gwe}, ins_valid, ins0, ins1, ins_pc, i1addr, i2addr);
    cmp({tag, " strobes"}, {12'h000, i1re, i2re, dre, gwe}, {12'h000, v.strb});
    cmp({tag, " ins_valid"}, {15'h0000, ins_valid}, {15'h0000, v.vld});
    cmp({tag, " i1addr"}, i1addr, v.a1);
    cmp({tag, " i2addr"}, i2addr, v.a2);
    if (v.chk_ins) begin
      cmp({tag, " ins0"}, ins0, v.i0);
      cmp({tag, " ins1"}, ins1, v.i1);
      cmp({tag, " ins_pc"}, ins_pc, v.ipc);
    end
  endtask

  vec_t tbl[23];

  initial begin
    // Reset, strobe sequence, first pairs, and back-pressure across 3 groups.
    tbl[0] = mk(1, 0, 0, 1, 4'b0000, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001);
    tbl[1] = tbl[0];
    for (int r = 2; r <= 5; r++)
      tbl[r] = mk(0, 0, 0, 1, ph(r - 2), 0, 0, 0, 0, 0, 16'h0000, 16'h0001);
    tbl[6] = mk(0, 0, 0, 1, ph(0), 1, 1, 16'h1000, 16'h1001, 16'h0000, 16'h0002, 16'h0003);
    for (int r = 7; r <= 18; r++)
      tbl[r] = mk(0, 0, 0, 0, ph(r - 6), 1, 1, 16'h1000, 16'h1001, 16'h0000, 16'h0002, 16'h0003);
    for (int r = 19; r <= 21; r++)
      tbl[r] = mk(0, 0, 0, 1, ph(r - 18), 0, 0, 0, 0, 0, 16'h0002, 16'h0003);
    tbl[22] = mk(0, 0, 0, 1, ph(0), 1, 1, 16'h1002, 16'h1003, 16'h0002, 16'h0004, 16'h0005);

    for (int r = 0; r < 23; r++)
      apply(tbl[r], $sformatf("vec%0d", r));

    // Redirect during phase 1, then overwritten during phase 2 (last wins).
    apply(mk(0, 0, 0, 0, ph(1), 1, 1, 16'h1002, 16'h1003, 16'h0002, 16'h0004, 16'h0005), "redir_a");
    apply(mk(0, 1, 16'h0200, 0, ph(2), 0, 0, 0, 0, 0, 16'h0004, 16'h0005), "redir_b");
    apply(mk(0, 1, 16'h0105, 0, ph(3), 0, 0, 0, 0, 0, 16'h0004, 16'h0005), "redir_c");
    apply(mk(0, 0, 0, 1, ph(0), 0, 0, 0, 0, 0, 16'h0105, 16'h0106), "redir_d");
    for (int p = 1; p <= 3; p++)
      apply(mk(0, 0, 0, 1, ph(p), 0, 0, 0, 0, 0, 16'h0105, 16'h0106), $sformatf("redir_p%0d", p));
    apply(mk(0, 0, 0, 1, ph(0), 1, 1, 16'h1105, 16'h1106, 16'h0105, 16'h0107, 16'h0108), "redir_cap");

    // Redirect exactly at the group-end edge to FFFF; checks pc wrap-around.
    for (int p = 1; p <= 3; p++)
      apply(mk(0, 0, 0, 1, ph(p), 0, 0, 0, 0, 0, 16'h0107, 16'h0108), $sformatf("wrap_p%0d", p));
    apply(mk(0, 1, 16'hFFFF, 1, ph(0), 0, 0, 0, 0, 0, 16'hFFFF, 16'h0000), "wrap_redir");
    for (int p = 1; p <= 3; p++)
      apply(mk(0, 0, 0, 1, ph(p), 0, 0, 0, 0, 0, 16'hFFFF, 16'h0000), $sformatf("wrap_q%0d", p));
    apply(mk(0, 0, 0, 1, ph(0), 1, 1, 16'h0FFF, 16'h1000, 16'hFFFF, 16'h0001, 16'h0002), "wrap_cap");

    // Reset asserted mid-group at phase 2 while a pair is held.
    apply(mk(0, 0, 0, 0, ph(1), 1, 1, 16'h0FFF, 16'h1000, 16'hFFFF, 16'h0001, 16'h0002), "rst_a");
    apply(mk(0, 0, 0, 0, ph(2), 1, 1, 16'h0FFF, 16'h1000, 16'hFFFF, 16'h0001, 16'h0002), "rst_b");
    rst = 1'b1;
    #1;
    $display("rst_gate: strb=%b", {i1re, i2re, dre, gwe});
    cmp("rst_gate strobes", {12'h000, i1re, i2re, dre, gwe}, 16'h0000);
    apply(mk(1, 0, 0, 0, 4'b0000, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001), "rst_c");
    apply(mk(0, 0, 0, 1, ph(0), 0, 0, 0, 0, 0, 16'h0000, 16'h0001), "rst_d");
    apply(mk(0, 0, 0, 1, ph(1), 0, 0, 0, 0, 0, 16'h0000, 16'h0001), "rst_e");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
